// File: rtl/arya_pkg.sv
// rtl/arya_pkg.sv - shared types and constants for the arya memory sequencer
package arya_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int RUN_W  = 16;

    // Instruction memory occupies the low half, data memory the high half.
    localparam logic [ADDR_W-1:0] INST_MEM_START = 10'd0;
    localparam logic [ADDR_W-1:0] DATA_MEM_START = 10'd512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_VDRAIN,
        ST_RUN
    } seq_state_t;

endpackage

// File: rtl/arya_verify_chk.sv
// rtl/arya_verify_chk.sv - readback compare pipeline with sticky first-error capture
module arya_verify_chk #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              capture,
    input  logic [DATA_W-1:0] host_data,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              verify_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              err_now
);

    logic [DATA_W-1:0] exp_q;
    logic              chk_v;
    logic [ADDR_W-1:0] chk_a;

    // mem_rdata arrives one cycle after the address, aligned with exp_q.
    assign err_now = chk_v && (mem_rdata != exp_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q      <= '0;
            chk_v      <= 1'b0;
            chk_a      <= '0;
            verify_err <= 1'b0;
            err_addr   <= '0;
        end else if (clear) begin
            chk_v      <= 1'b0;
            verify_err <= 1'b0;
            err_addr   <= '0;
        end else begin
            chk_v <= capture;
            if (capture) begin
                exp_q <= host_data;
                chk_a <= addr;
            end
            if (err_now && !verify_err) begin
                verify_err <= 1'b1;
                err_addr   <= chk_a;
            end
        end
    end

endmodule

// File: rtl/arya_mem_sequencer.sv
// rtl/arya_mem_sequencer.sv - load/verify/run sequencer for the arya core's shared memory port A
module arya_mem_sequencer
    import arya_pkg::*;
#(
    parameter int ADDR_W = arya_pkg::ADDR_W,
    parameter int DATA_W = arya_pkg::DATA_W,
    parameter int RUN_W  = arya_pkg::RUN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic              verify_req,
    input  logic [RUN_W-1:0]  run_cycles,
    input  logic              halt,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              setup_mem,
    output logic              verify_mem,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_en,
    output logic              busy,
    output logic              done,
    output logic              verify_err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] IDX_ONE = 1;
    localparam logic [RUN_W-1:0]  RUN_ONE = 1;

    seq_state_t        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic              verify_q;
    logic [RUN_W-1:0]  run_q;
    logic [ADDR_W-1:0] idx;
    logic [RUN_W-1:0]  run_cnt;

    logic hs;
    logic load_hs;
    logic verify_hs;
    logic last_beat;
    logic run_last;
    logic err_now;
    logic chk_clear;

    assign hs        = host_valid & host_ready;
    assign load_hs   = hs & (state == ST_LOAD);
    assign verify_hs = hs & (state == ST_VERIFY);
    assign last_beat = (idx == len_q);
    assign run_last  = (run_q != '0) && (run_cnt == run_q - RUN_ONE);
    assign chk_clear = (state == ST_IDLE) & start;

    // Address holds between handshakes so a stalled readback stays aligned.
    assign mem_addr  = (state == ST_LOAD || state == ST_VERIFY) ? base_q + idx : '0;
    assign setup_mem = load_hs;
    assign mem_wdata = load_hs ? host_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            verify_q   <= 1'b0;
            run_q      <= '0;
            idx        <= '0;
            run_cnt    <= '0;
            host_ready <= 1'b0;
            verify_mem <= 1'b0;
            core_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        len_q      <= len_m1;
                        verify_q   <= verify_req;
                        run_q      <= run_cycles;
                        idx        <= '0;
                        run_cnt    <= '0;
                        host_ready <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_hs) begin
                        if (last_beat) begin
                            idx <= '0;
                            if (verify_q) begin
                                verify_mem <= 1'b1;
                                state      <= ST_VERIFY;
                            end else begin
                                host_ready <= 1'b0;
                                core_en    <= 1'b1;
                                run_cnt    <= '0;
                                state      <= ST_RUN;
                            end
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (verify_hs) begin
                        if (last_beat) begin
                            idx        <= '0;
                            host_ready <= 1'b0;
                            state      <= ST_VDRAIN;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                ST_VDRAIN: begin
                    verify_mem <= 1'b0;
                    if (verify_err || err_now) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        core_en <= 1'b1;
                        run_cnt <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    run_cnt <= run_cnt + RUN_ONE;
                    if (halt || run_last) begin
                        core_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    host_ready <= 1'b0;
                    verify_mem <= 1'b0;
                    core_en    <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    arya_verify_chk #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_verify_chk (
        .clk        (clk),
        .reset      (reset),
        .clear      (chk_clear),
        .capture    (verify_hs),
        .host_data  (host_data),
        .addr       (mem_addr),
        .mem_rdata  (mem_rdata),
        .verify_err (verify_err),
        .err_addr   (err_addr),
        .err_now    (err_now)
    );

endmodule

// File: tb/tb_arya_mem_sequencer.sv
// tb/tb_arya_mem_sequencer.sv - randomized self-checking bench for arya_mem_sequencer
module tb_arya_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  len_m1;
    logic        verify_req;
    logic [15:0] run_cycles;
    logic        halt;
    logic        host_valid;
    logic [63:0] host_data;
    logic        host_ready;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        setup_mem;
    logic        verify_mem;
    logic [63:0] mem_rdata;
    logic        core_en;
    logic        busy;
    logic        done;
    logic        verify_err;
    logic [9:0]  err_addr;

    int vectors = 0;
    int miscompares = 0;

    arya_mem_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .len_m1     (len_m1),
        .verify_req (verify_req),
        .run_cycles (run_cycles),
        .halt       (halt),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .setup_mem  (setup_mem),
        .verify_mem (verify_mem),
        .mem_rdata  (mem_rdata),
        .core_en    (core_en),
        .busy       (busy),
        .done       (done),
        .verify_err (verify_err),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    // Port A of the core's memory: synchronous write, registered read.
    logic [63:0] mem [0:1023];
    always @(posedge clk) begin
        if (setup_mem) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [9:0]  wr_a [$];
    logic [63:0] wr_d [$];
    logic [9:0]  va_q [$];
    logic        vv_q [$];
    logic [63:0] sent_q [$];
    int en_cnt, vm_cnt, done_cnt, excl_cnt, first_en, last_en, done_cyc, t0;
    logic done_busy;

    always @(negedge clk) begin
        if (setup_mem) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
        end
        if (core_en) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
        end
        if (verify_mem) vm_cnt++;
        if (verify_mem && host_ready) begin
            va_q.push_back(mem_addr);
            vv_q.push_back(host_valid);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_busy = busy;
        end
        if (int'(core_en) + int'(setup_mem) + int'(verify_mem) > 1) excl_cnt++;
    end

    task automatic do_seq(input logic [9:0] base, input int n, input bit ver, input int runc,
                          input int bad, input bit gaps, input int halt_after, input bit restart);
        bit halt_sent = 0;
        @(posedge clk); #1;
        wr_a.delete(); wr_d.delete(); va_q.delete(); vv_q.delete(); sent_q.delete();
        en_cnt = 0; vm_cnt = 0; done_cnt = 0; excl_cnt = 0;
        first_en = -1; last_en = -1; done_cyc = -1; done_busy = 1'b1;
        for (int i = 0; i < n; i++) sent_q.push_back({$urandom, $urandom});
        start = 1; base_addr = base; len_m1 = 10'(n - 1); verify_req = ver; run_cycles = 16'(runc);
        @(negedge clk); t0 = cyc;
        @(posedge clk); #1;
        start = restart;
        if (restart) begin
            base_addr = base ^ 10'h155; len_m1 = 10'd0; verify_req = ~ver; run_cycles = 16'd1;
        end
        for (int i = 0; i < n; i++) begin
            host_valid = 1; host_data = sent_q[i];
            @(posedge clk); #1;
            start = 0;
            if (gaps && i < n - 1) begin
                host_valid = 0; host_data = {$urandom, $urandom};
                @(posedge clk); #1;
            end
        end
        host_valid = 0;
        if (ver) begin
            for (int i = 0; i < n; i++) begin
                host_valid = 1;
                host_data = (i == bad) ? sent_q[i] ^ 64'h1 : sent_q[i];
                @(posedge clk); #1;
                if (gaps && i < n - 1) begin
                    host_valid = 0; host_data = {$urandom, $urandom};
                    @(posedge clk); #1;
                end
            end
            host_valid = 0;
        end
        for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
            @(negedge clk); #1;
            if (halt_after > 0 && en_cnt == halt_after && !halt_sent) begin
                halt = 1; halt_sent = 1;
                @(posedge clk); #1;
                halt = 0;
            end
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        vectors++;
        if ({busy, host_ready, setup_mem, verify_mem, core_en, done, verify_err, err_addr, mem_addr, mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%0b rdy=%0b setup=%0b vmem=%0b en=%0b done=%0b err=%0b ea=%h addr=%h wd=%h, want all 0",
                     busy, host_ready, setup_mem, verify_mem, core_en, done, verify_err, err_addr, mem_addr, mem_wdata);
        end
        reset = 1;
    endtask

    task automatic test_basic;
        do_seq(10'h010, 4, 0, 5, -1, 0, 0, 0);
        vectors++;
        if (wr_a.size() !== 4) begin
            miscompares++; $display("FAIL basic_wr_count: got %0d want 4", wr_a.size());
        end
        for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
            vectors++;
            if ({wr_a[i], wr_d[i]} !== {10'(16 + i), sent_q[i]}) begin
                miscompares++;
                $display("FAIL basic_wr%0d: got %h/%h want %h/%h", i, wr_a[i], wr_d[i], 10'(16 + i), sent_q[i]);
            end
        end
        vectors++;
        if (en_cnt !== 5) begin miscompares++; $display("FAIL basic_en_cycles: got %0d want 5", en_cnt); end
        vectors++;
        if (first_en - t0 !== 5) begin miscompares++; $display("FAIL basic_en_latency: got %0d want 5", first_en - t0); end
        vectors++;
        if ({done_cnt, done_busy, busy} !== {32'd1, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL basic_done: pulses=%0d busy_at_done=%0b busy=%0b want 1/0/0", done_cnt, done_busy, busy);
        end
        vectors++;
        if (excl_cnt !== 0) begin miscompares++; $display("FAIL basic_exclusive: got %0d want 0", excl_cnt); end
    endtask

    task automatic test_verify_pass;
        do_seq(10'h010, 4, 1, 5, -1, 0, 0, 0);
        vectors++;
        if (verify_err !== 1'b0) begin miscompares++; $display("FAIL vpass_err: got %0b want 0", verify_err); end
        vectors++;
        if (vm_cnt !== 5) begin miscompares++; $display("FAIL vpass_vmem_cycles: got %0d want 5", vm_cnt); end
        vectors++;
        if ({en_cnt, first_en - t0} !== {32'd5, 32'd10}) begin
            miscompares++; $display("FAIL vpass_run: en=%0d latency=%0d want 5/10", en_cnt, first_en - t0);
        end
        vectors++;
        if (excl_cnt !== 0) begin miscompares++; $display("FAIL vpass_exclusive: got %0d want 0", excl_cnt); end
    endtask

    task automatic test_verify_mismatch;
        do_seq(10'h010, 4, 1, 5, 2, 0, 0, 0);
        vectors++;
        if ({verify_err, err_addr} !== {1'b1, 10'h012}) begin
            miscompares++; $display("FAIL vfail_err: got %0b/%h want 1/012", verify_err, err_addr);
        end
        vectors++;
        if (en_cnt !== 0) begin miscompares++; $display("FAIL vfail_no_run: got %0d want 0", en_cnt); end
        vectors++;
        if ({done_cnt, done_cyc - t0} !== {32'd1, 32'd10}) begin
            miscompares++; $display("FAIL vfail_done: pulses=%0d at=%0d want 1/10", done_cnt, done_cyc - t0);
        end
    endtask

    task automatic test_wrap_backpressure;
        int runc = $urandom_range(1, 8);
        int k = 0;
        logic [9:0] ea;
        do_seq(10'h3FE, 4, 1, runc, -1, 1, 0, 0);
        vectors++;
        if (wr_a.size() !== 4) begin miscompares++; $display("FAIL wrap_wr_count: got %0d want 4", wr_a.size()); end
        for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
            ea = 10'((1022 + i) % 1024);
            vectors++;
            if ({wr_a[i], wr_d[i]} !== {ea, sent_q[i]}) begin
                miscompares++; $display("FAIL wrap_wr%0d: got %h/%h want %h/%h", i, wr_a[i], wr_d[i], ea, sent_q[i]);
            end
        end
        vectors++;
        if (va_q.size() !== 7) begin miscompares++; $display("FAIL wrap_verify_cycles: got %0d want 7", va_q.size()); end
        for (int i = 0; i < va_q.size(); i++) begin
            ea = 10'((1022 + k) % 1024);
            vectors++;
            if (va_q[i] !== ea) begin
                miscompares++; $display("FAIL wrap_vaddr%0d: got %h want %h", i, va_q[i], ea);
            end
            if (vv_q[i]) k++;
        end
        vectors++;
        if ({verify_err, en_cnt, vm_cnt} !== {1'b0, 32'(runc), 32'd8}) begin
            miscompares++; $display("FAIL wrap_result: err=%0b en=%0d vmem=%0d want 0/%0d/8", verify_err, en_cnt, vm_cnt, runc);
        end
    endtask

    task automatic test_halt;
        do_seq(10'($urandom), $urandom_range(1, 6), 0, 0, -1, 0, 20, 0);
        vectors++;
        if (en_cnt !== 20) begin miscompares++; $display("FAIL halt_en_cycles: got %0d want 20", en_cnt); end
        vectors++;
        if ({done_cnt, done_cyc - last_en, busy} !== {32'd1, 32'd1, 1'b0}) begin
            miscompares++; $display("FAIL halt_done: pulses=%0d gap=%0d busy=%0b want 1/1/0", done_cnt, done_cyc - last_en, busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] w0 = {$urandom, $urandom};
        @(posedge clk); #1;
        start = 1; base_addr = 10'h050; len_m1 = 10'd3; verify_req = 0; run_cycles = 16'd4;
        @(posedge clk); #1;
        start = 0; host_valid = 1; host_data = w0;
        @(posedge clk); #1;
        host_data = {$urandom, $urandom};
        #2 reset = 0;
        #1;
        vectors++;
        if ({busy, host_ready, setup_mem, verify_mem, core_en, done, verify_err, err_addr, mem_addr, mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: busy=%0b rdy=%0b setup=%0b vmem=%0b en=%0b addr=%h, want all 0",
                     busy, host_ready, setup_mem, verify_mem, core_en, mem_addr);
        end
        vectors++;
        if (mem[10'h050] !== w0) begin miscompares++; $display("FAIL midreset_kept: got %h want %h", mem[10'h050], w0); end
        host_valid = 0;
        @(posedge clk); #1 reset = 1;
        do_seq(10'h050, 4, 0, 4, -1, 0, 0, 1);
        vectors++;
        if ({wr_a.size(), en_cnt, done_cnt} !== {32'd4, 32'd4, 32'd1}) begin
            miscompares++; $display("FAIL midreset_restart: wr=%0d en=%0d done=%0d want 4/4/1", wr_a.size(), en_cnt, done_cnt);
        end
        for (int i = 0; i < wr_a.size(); i++) begin
            vectors++;
            if ({wr_a[i], wr_d[i]} !== {10'(80 + i), sent_q[i]}) begin
                miscompares++; $display("FAIL midreset_wr%0d: got %h/%h want %h/%h", i, wr_a[i], wr_d[i], 10'(80 + i), sent_q[i]);
            end
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 16; r++) begin
            logic [9:0] base = 10'($urandom);
            int n = $urandom_range(1, 12);
            bit ver = 1'($urandom);
            int runc = $urandom_range(1, 10);
            int bad = (ver && $urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            int exp_en = (bad >= 0) ? 0 : runc;
            logic [9:0] exp_ea = (bad >= 0) ? 10'((int'(base) + bad) % 1024) : 10'd0;
            do_seq(base, n, ver, runc, bad, 1'($urandom), 0, 1'($urandom));
            vectors++;
            if (wr_a.size() !== n) begin miscompares++; $display("FAIL rand%0d_wr_count: got %0d want %0d", r, wr_a.size(), n); end
            for (int i = 0; i < n && i < wr_a.size(); i++) begin
                vectors++;
                if ({wr_a[i], wr_d[i]} !== {10'((int'(base) + i) % 1024), sent_q[i]}) begin
                    miscompares++;
                    $display("FAIL rand%0d_wr%0d: got %h/%h want %h/%h", r, i, wr_a[i], wr_d[i], 10'((int'(base) + i) % 1024), sent_q[i]);
                end
            end
            vectors++;
            if ({verify_err, err_addr, en_cnt, done_cnt, excl_cnt} !== {bad >= 0, exp_ea, 32'(exp_en), 32'd1, 32'd0}) begin
                miscompares++;
                $display("FAIL rand%0d_result: err=%0b ea=%h en=%0d done=%0d excl=%0d want %0b/%h/%0d/1/0",
                         r, verify_err, err_addr, en_cnt, done_cnt, excl_cnt, bad >= 0, exp_ea, exp_en);
            end
        end
    endtask

    initial begin
        reset = 0; start = 0; base_addr = '0; len_m1 = '0; verify_req = 0;
        run_cycles = '0; halt = 0; host_valid = 0; host_data = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_verify_pass();
        test_verify_mismatch();
        test_wrap_backpressure();
        test_halt();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arya_mem_sequencer.md
# arya_mem_sequencer

Controller that sequences the arya core's shared dual-port memory through three phases: load, verify and run. It streams host words into the instruction/data memory over port A, optionally reads them back and compares against a second host pass, then releases the core enable for a bounded or open-ended run. It sits between the host/testbench and the core's `mem_addr_in`, `mem_data_in`, `setup_mem`, `verify_mem`, `en` and `mem_data_out` pins. It guarantees that port A is never shared between debug access and instruction fetch in the same cycle.

## Interface
- `ADDR_W`, 10: memory address width.
- `DATA_W`, 64: memory word width.
- `RUN_W`, 16: run-cycle counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sequence; ignored while `busy`.
- `base_addr`  in  ADDR_W  first memory address, latched on `start`.
- `len_m1`  in  ADDR_W  word count minus 1, latched on `start`.
- `verify_req`  in  1  run a readback pass after load; latched on `start`.
- `run_cycles`  in  RUN_W  core run length; 0 means run until `halt`. Latched on `start`.
- `halt`  in  1  stops RUN.
- `host_valid`  in  1  host word valid.
- `host_data`  in  DATA_W  host word.
- `host_ready`  out  1  sequencer accepts `host_data` this cycle.
- `mem_addr`  out  ADDR_W  drives the core's `mem_addr_in`.
- `mem_wdata`  out  DATA_W  drives the core's `mem_data_in`.
- `setup_mem`  out  1  port-A write enable.
- `verify_mem`  out  1  port-A debug read select.
- `mem_rdata`  in  DATA_W  the core's `mem_data_out` (port A `douta`), registered 1 cycle after address.
- `core_en`  out  1  core pipeline enable.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE.
- `verify_err`  out  1  sticky mismatch flag; cleared on `start`.
- `err_addr`  out  ADDR_W  address of the first mismatch.

## Operation
- States: IDLE, LOAD, VERIFY, VDRAIN, RUN.
- IDLE:
  - `start` latches all configuration inputs, clears `idx`, `verify_err` and `err_addr`, then moves to LOAD.
- LOAD:
  - `host_ready`=1.
  - On each beat where `host_valid` and `host_ready` are both high: `setup_mem`=1, `mem_addr`=`base_addr`+`idx`, `mem_wdata`=`host_data`, and `idx` increments.
  - `setup_mem` is combinational on the handshake; it is 0 on idle beats.
  - After the beat with `idx`==`len_m1`: `idx` clears and the block moves to VERIFY if `verify_req`, else to RUN.
- VERIFY:
  - `verify_mem`=1 and `host_ready`=1.
  - `mem_addr`=`base_addr`+`idx` every cycle.
  - On a handshake: register `exp`←`host_data`, set `chk_v`←1 and `chk_a`←`mem_addr`, and increment `idx`. With no handshake, `chk_v`←0.
  - Compare stage: when `chk_v`=1, compare `mem_rdata` with `exp`. On a mismatch, set `verify_err`; the first mismatch captures `err_addr`←`chk_a`.
  - After the beat with `idx`==`len_m1`, move to VDRAIN.
  - Because `mem_addr` holds when no handshake occurs, `mem_rdata` always reflects `chk_a` in the compare cycle.
- VDRAIN:
  - Lasts one cycle. `verify_mem`=1 and `host_ready`=0. The final compare is performed.
  - Next state is IDLE with `done` if `verify_err` is set (including a mismatch found this cycle); otherwise RUN.
- RUN:
  - `core_en`=1 and `run_cnt` increments each cycle.
  - Exit to IDLE with `done` when `halt`=1, or when `run_cycles`≠0 and `run_cnt`==`run_cycles`−1.
  - With `run_cycles`≠0, `core_en` is high for exactly `run_cycles` cycles.
- Address arithmetic: `base_addr`+`idx` is computed mod 2^ADDR_W, so addresses wrap from 0x3FF to 0x000.
- Invariants:
  - `core_en`, `setup_mem` and `verify_mem` are mutually exclusive.
  - `host_ready`=0 in IDLE, VDRAIN and RUN.
- Reset (asynchronous, any state, including mid-phase):
  - State→IDLE.
  - All outputs 0, all counters 0, `verify_err`=0, `err_addr`=0.
  - The memory contents already written are not rolled back.

## Timing
- `start` in cycle t puts the block in LOAD at t+1, which is also the earliest possible write.
- Write latency: a host beat is written into memory on the same clock edge as the handshake.
- Readback: address at cycle t, compare at t+1. The pipeline sustains one word per cycle.
- LOAD→RUN with no host stalls:
  - Length N gives the first `core_en` at t+1+N.
  - With verify, the first `core_en` is at t+1+2N+1.
- `halt` sampled high at edge e causes `core_en` to go low and `done`=1 in the cycle after e.
- `done` is high for exactly one cycle and coincides with the first IDLE cycle.
- `start` during `busy` is ignored, with no side effects.

## Structure
- Shared package `arya_pkg`:
  - `seq_state_t` enum.
  - `ADDR_W`/`DATA_W` constants.
  - `DATA_MEM_START` (512) and `INST_MEM_START` (0).
- One sub-module, `arya_verify_chk`: the expected-data register, `chk_v`/`chk_a` pipeline, comparator, sticky error flag and first-error address capture.
- The FSM, `idx` and `run_cnt` live in the top module.

## Test plan
- **Basic load and run:** `base_addr`=0x010, `len_m1`=3, no verify, `run_cycles`=5, back-to-back host words A..D.
  - `setup_mem` pulses at 0x010–0x013 with data A–D.
  - Then `core_en` high for 5 cycles, one `done`, `busy` low.
- **Verify pass:** same load, then the host re-streams A..D. Expect `verify_err`=0, `verify_mem` high for 5 cycles, then RUN entered.
- **Verify mismatch:** the third re-streamed word differs from memory. Expect `verify_err`=1, `err_addr`=0x012, `core_en` never asserted, and `done` one cycle after VDRAIN.
- **Wrap and backpressure:** `base_addr`=0x3FE, `len_m1`=3, `host_valid` toggling 1,0,1,0.
  - Writes land at 0x3FE, 0x3FF, 0x000, 0x001, only on valid beats.
  - `mem_addr` holds across gaps in VERIFY.
- **Halt in open-ended run:** `run_cycles`=0, `halt` asserted after 20 RUN cycles. Expect `core_en` low the next cycle and `done`=1.
- **Reset mid-operation:** `reset` low during LOAD word 2, then a `start` issued while busy is ignored.
  - All outputs go 0 immediately on reset.
  - After release, a fresh `start` completes normally.
